// File: rtl/debug_uart_tx.sv
// debug_uart_tx: sends the seven 8-bit CPU debug ports to the host debugger
// as one 8N1 UART frame. Each frame is SYNC_BYTE followed by port1..port7.
// All eight bytes come from a snapshot taken in the cycle the frame is accepted.
// tx, busy and done all come straight from flops, so tx cannot glitch.

module debug_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,    // 100 MHz / 115200 baud, must be >= 2
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5   // frame alignment marker for the host
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // The baud counter runs 0..CLKS_PER_BIT-1 and wraps exactly at each bit
  // boundary. Every bit therefore lasts the same number of cycles and the
  // frame timing cannot drift.
  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [2:0]        bit_q,   bit_d;
  logic [2:0]        byte_q,  byte_d;
  logic [7:0][7:0]   snap_q,  snap_d;   // [byte][bit]; byte 0 is the sync byte
  logic              tx_q,    tx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic              bit_end_s;
  logic [2:0]        nxt_bit_s;

  assign bit_end_s = (cnt_q == CNT_LAST);
  assign nxt_bit_s = bit_q + 3'd1;

  // Next-state and next-output logic. tx_d holds the level for the cycle
  // after the coming edge, so the line changes exactly on a bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start && !busy_q) begin
          // One-cycle snapshot: later port changes cannot affect this frame.
          snap_d[0] = SYNC_BYTE;
          snap_d[1] = debug_port1;
          snap_d[2] = debug_port2;
          snap_d[3] = debug_port3;
          snap_d[4] = debug_port4;
          snap_d[5] = debug_port5;
          snap_d[6] = debug_port6;
          snap_d[7] = debug_port7;
          byte_d    = 3'd0;
          bit_d     = 3'd0;
          cnt_d     = '0;
          state_d   = ST_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = snap_q[byte_q][0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = nxt_bit_s;
            tx_d  = snap_q[byte_q][nxt_bit_s];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (byte_q == 3'd7) begin
            // Frame complete. busy drops in the same cycle that done pulses,
            // so a start in the done cycle is accepted right after it.
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            // The next start bit follows the stop bit with no idle gap.
            byte_d  = byte_q + 3'd1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
        byte_d  = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, snapshot and output registers. Reset is asynchronous and
  // aborts any frame in flight without producing a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
